// File: rtl/edsac_timing_pkg.sv
// Shared timing definitions: digit-count default, generator states, control-consumed digit positions.
// Pure declarations, no logic or latency.
// No flow control; consumers only read these constants.
package edsac_timing_pkg;

    localparam int DIGITS_DEFAULT = 36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    // Digit positions sampled by control_section.
    localparam int D_SIGN         = 0;
    localparam int D_ADDR_LO      = 1;
    localparam int D_ADDR_B2      = 2;
    localparam int D_SHORT_LONG   = 7;
    localparam int D_FUNC_LO      = 18;
    localparam int D_FUNC_HI      = 20;
    localparam int D_ADDR_FLD_LO  = 25;
    localparam int D_ADDR_FLD_HI  = 29;
    localparam int D_ORDER_HI     = 31;
    localparam int D_ORDER_LAST   = 35;

    function automatic logic is_active(input state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/digit_pulse_generator_if.sv
// Bus between the Starter Unit / consumers (master) and the digit pulse generator (slave).
// Wires only, no latency.
// No backpressure; requests are levels or single-cycle pulses.
interface digit_pulse_generator_if
    import edsac_timing_pkg::*;
#(
    parameter int DIGITS  = DIGITS_DEFAULT,
    parameter int DW      = 6,
    parameter int MINOR_W = 10
);
    logic               run;
    logic               stop_one;
    logic [DIGITS-1:0]  d;
    logic [DW-1:0]      digit_idx;
    logic               minor_start;
    logic               minor_end;
    logic               cycle_odd;
    logic [MINOR_W-1:0] minor_count;
    logic               running;
    logic               step_done;

    modport master (
        output run, stop_one,
        input  d, digit_idx, minor_start, minor_end, cycle_odd, minor_count, running, step_done
    );

    modport slave (
        input  run, stop_one,
        output d, digit_idx, minor_start, minor_end, cycle_odd, minor_count, running, step_done
    );
endinterface

// File: rtl/digit_pulse_generator_counter.sv
// Mod-MODULUS digit position counter with enable, wrap flag and synchronous clear.
// Count register updates one clock after enable; next value is exposed combinationally.
// No backpressure; clear overrides enable.
module digit_counter #(
    parameter int MODULUS = 36,
    parameter int W       = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt_q,
    output logic [W-1:0] cnt_d,
    output logic         wrap
);

    assign wrap = (cnt_q == W'(MODULUS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_pulse_generator.sv
// Minor-cycle timing source: one-hot digit pulses, boundary strobes, cycle parity/count, run/step gating.
// First d[0] one clock after run/stop_one is sampled; all outputs registered.
// No backpressure; run/stop_one only take effect at minor-cycle boundaries.
module digit_pulse_generator
    import edsac_timing_pkg::*;
#(
    parameter int DIGITS  = DIGITS_DEFAULT,
    parameter int DW      = 6,
    parameter int MINOR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    digit_pulse_generator_if.slave   bus
);

    state_t               state_q, state_d;
    logic [DW-1:0]        idx_q, idx_d;
    logic                 wrap;
    logic                 cnt_en, cnt_clr;
    logic                 end_of_minor;
    logic                 active_d;

    logic [DIGITS-1:0]    d_q, d_d;
    logic                 minor_start_q, minor_start_d;
    logic                 minor_end_q, minor_end_d;
    logic                 cycle_odd_q, cycle_odd_d;
    logic [MINOR_W-1:0]   minor_count_q, minor_count_d;
    logic                 step_done_q, step_done_d;

    digit_counter #(
        .MODULUS (DIGITS),
        .W       (DW)
    ) u_digit_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .cnt_q (idx_q),
        .cnt_d (idx_d),
        .wrap  (wrap)
    );

    // Requests are only honoured in IDLE; RUN/STEP decide their fate at the last digit.
    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = RUN;
                end else if (bus.stop_one) begin
                    state_d = STEP;
                end
            end
            RUN, STEP: begin
                cnt_en = 1'b1;
                if (wrap) begin
                    if (bus.run) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Decode from the next position so the pulses line up with the registered digit_idx.
    always_comb begin
        end_of_minor  = is_active(state_q) && wrap;
        active_d      = is_active(state_d);
        d_d           = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d_d[k] = active_d && (idx_d == DW'(k));
        end
        minor_start_d = active_d && (idx_d == '0);
        minor_end_d   = active_d && (idx_d == DW'(DIGITS - 1));
        cycle_odd_d   = cycle_odd_q ^ end_of_minor;
        minor_count_d = minor_count_q + MINOR_W'(end_of_minor);
        step_done_d   = (state_q == STEP) && wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            d_q           <= '0;
            minor_start_q <= 1'b0;
            minor_end_q   <= 1'b0;
            cycle_odd_q   <= 1'b0;
            minor_count_q <= '0;
            step_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            d_q           <= d_d;
            minor_start_q <= minor_start_d;
            minor_end_q   <= minor_end_d;
            cycle_odd_q   <= cycle_odd_d;
            minor_count_q <= minor_count_d;
            step_done_q   <= step_done_d;
        end
    end

    assign bus.d           = d_q;
    assign bus.digit_idx   = idx_q;
    assign bus.minor_start = minor_start_q;
    assign bus.minor_end   = minor_end_q;
    assign bus.cycle_odd   = cycle_odd_q;
    assign bus.minor_count = minor_count_q;
    assign bus.running     = is_active(state_q);
    assign bus.step_done   = step_done_q;

endmodule

// File: tb/tb_digit_pulse_generator.sv
// Self-checking bench: directed scenarios plus random run/step/reset traffic against a behavioural model.
module tb_digit_pulse_generator;

    localparam int D = 36;

    logic clk;
    logic rst_i;
    logic run_i;
    logic stop_i;

    digit_pulse_generator_if #(.DIGITS(D), .DW(6), .MINOR_W(10)) bus ();
    digit_pulse_generator_if #(.DIGITS(D), .DW(6), .MINOR_W(3))  bus3 ();

    assign bus.run       = run_i;
    assign bus.stop_one  = stop_i;
    assign bus3.run      = run_i;
    assign bus3.stop_one = stop_i;

    digit_pulse_generator #(.DIGITS(D), .DW(6), .MINOR_W(10)) dut (
        .clk   (clk),
        .reset (rst_i),
        .bus   (bus)
    );

    digit_pulse_generator #(.DIGITS(D), .DW(6), .MINOR_W(3)) dut3 (
        .clk   (clk),
        .reset (rst_i),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_pulse = 0;
    int n_sd    = 0;
    int last_start = 0;
    bit have_start = 0;

    // Behavioural model: is a minor cycle in progress, which digit, and was it a single step.
    bit m_active = 0;
    bit m_step   = 0;
    int m_pos    = 0;
    int m_count  = 0;
    bit m_odd    = 0;
    bit m_sd     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit done;
        if (rst_i) begin
            m_active = 0; m_step = 0; m_pos = 0;
            m_count = 0; m_odd = 0; m_sd = 0;
        end else begin
            done = m_active && (m_pos == D - 1);
            m_sd = done && m_step;
            if (done) begin
                m_count++;
                m_odd = !m_odd;
            end
            if (!m_active) begin
                if (run_i) begin
                    m_active = 1; m_step = 0; m_pos = 0;
                end else if (stop_i) begin
                    m_active = 1; m_step = 1; m_pos = 0;
                end
            end else if (!done) begin
                m_pos++;
            end else if (run_i) begin
                m_pos = 0; m_step = 0;
            end else begin
                m_active = 0; m_step = 0; m_pos = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [D-1:0] ed;
        ed = m_active ? (36'd1 << m_pos) : 36'd0;
        chk("d",           64'(bus.d), 64'(ed));
        chk("digit_idx",   64'(bus.digit_idx), 64'(m_pos));
        chk("minor_start", 64'(bus.minor_start), 64'(m_active && m_pos == 0));
        chk("minor_end",   64'(bus.minor_end), 64'(m_active && m_pos == D - 1));
        chk("running",     64'(bus.running), 64'(m_active));
        chk("cycle_odd",   64'(bus.cycle_odd), 64'(m_odd));
        chk("minor_count", 64'(bus.minor_count), 64'(m_count % 1024));
        chk("step_done",   64'(bus.step_done), 64'(m_sd));
        chk("d_w3",        64'(bus3.d), 64'(ed));
        chk("minor_count_w3", 64'(bus3.minor_count), 64'(m_count % 8));
        chk("onehot0",     64'($onehot0(bus.d)), 64'd1);
        chk("start_has_d0", 64'(!bus.minor_start || bus.d[0]), 64'd1);
        chk("end_has_dlast", 64'(!bus.minor_end || bus.d[D-1]), 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare_all();
        if (bus.d != '0) n_pulse++;
        if (bus.step_done) n_sd++;
        if (!bus.running) begin
            have_start = 0;
        end else if (bus.minor_start) begin
            if (have_start) chk("start_period", 64'(cyc - last_start), 64'(D));
            last_start = cyc;
            have_start = 1;
        end
    endtask

    task automatic wait_idx(input int v, input string tag);
        int n;
        n = 0;
        while (int'(bus.digit_idx) != v && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(int'(bus.digit_idx) == v), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus.running && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(bus.running), 64'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        int starts[3];
        int ns;
        int n;
        int p0, s0;

        rst_i = 1'b1; run_i = 1'b0; stop_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Continuous run: starts at clocks 1, 37, 73.
        ns = 0;
        run_i = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (bus.minor_start) begin
                if (ns < 3) starts[ns] = i;
                ns++;
            end
            if (i == 73) begin
                chk("run_count_at_73", 64'(bus.minor_count), 64'd2);
                chk("run_odd_at_73", 64'(bus.cycle_odd), 64'd0);
            end
        end
        chk("n_starts", 64'(ns), 64'd3);
        chk("start_0", 64'(starts[0]), 64'd1);
        chk("start_1", 64'(starts[1]), 64'd37);
        chk("start_2", 64'(starts[2]), 64'd73);

        // Drop run mid-cycle: cycle still completes.
        wait_idx(10, "wait_idx10");
        run_i = 1'b0;
        n = 0;
        while (bus.running && n < 100) begin
            tick();
            n++;
        end
        chk("drop_ticks", 64'(n), 64'd26);
        chk("drop_idx", 64'(bus.digit_idx), 64'd0);
        chk("drop_d", 64'(bus.d), 64'd0);

        // Single step from reset.
        do_reset();
        p0 = n_pulse; s0 = n_sd;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        drain();
        chk("step_pulses", 64'(n_pulse - p0), 64'd36);
        chk("step_done_cnt", 64'(n_sd - s0), 64'd1);
        chk("step_count", 64'(bus.minor_count), 64'd1);
        chk("step_odd", 64'(bus.cycle_odd), 64'd1);

        // stop_one during a step is not queued.
        p0 = n_pulse; s0 = n_sd;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wait_idx(5, "wait_idx5");
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        drain();
        repeat (5) tick();
        chk("restep_pulses", 64'(n_pulse - p0), 64'd36);
        chk("restep_done_cnt", 64'(n_sd - s0), 64'd1);

        // run and stop_one together: RUN wins, no step_done.
        p0 = n_pulse; s0 = n_sd;
        run_i = 1'b1; stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        repeat (40) tick();
        run_i = 1'b0;
        drain();
        tick();
        chk("simul_pulses", 64'(n_pulse - p0), 64'd72);
        chk("simul_step_done", 64'(n_sd - s0), 64'd0);

        // Reset mid-run, then restart; narrow counter wraps 1..7,0,1.
        run_i = 1'b1;
        tick();
        wait_idx(20, "wait_idx20");
        rst_i = 1'b1;
        tick();
        chk("rst_mid_d", 64'(bus.d), 64'd0);
        chk("rst_mid_running", 64'(bus.running), 64'd0);
        rst_i = 1'b0;
        tick();
        chk("rst_rel_d", 64'(bus.d), 64'd1);
        chk("rst_rel_count", 64'(bus.minor_count), 64'd0);
        for (int k = 1; k <= 9; k++) begin
            repeat (D) tick();
            chk("count_w3_seq", 64'(bus3.minor_count), 64'(k % 8));
        end
        run_i = 1'b0;
        drain();

        // Random run/stop_one/reset traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(39, 0) == 0) run_i = !run_i;
            stop_i = ($urandom_range(11, 0) == 0);
            rst_i  = ($urandom_range(399, 0) == 0);
            tick();
        end
        rst_i = 1'b0; stop_i = 1'b0; run_i = 1'b0;
        drain();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_pulse_generator.md
Name: digit_pulse_generator

Overview:
- Timing source for the Control Section and the arithmetic units.
- Produces the one-hot digit pulses d0..d(DIGITS-1) of each minor cycle, a minor-cycle counter with an odd/even flag, and minor-cycle boundary strobes.
- Gates the pulse train on and off at minor-cycle boundaries under run, stop and single-step requests from the Starter Unit.
- Sits directly upstream of control_section; control_section samples d0, d1, d2, d7, d18–d20, d25–d29 and d31–d35 from this block's bus.

Parameters:
- DIGITS, 36, digit positions per minor cycle; legal range 4..64.
- DW, 6, width of digit_idx; must satisfy 2^DW >= DIGITS.
- MINOR_W, 10, width of the free-running minor-cycle counter.

Ports:
- clk  in  1  system clock; one digit position per clock while running.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = continuous running requested.
- stop_one  in  1  single-cycle pulse; request exactly one minor cycle while not running.
- d  out  DIGITS  one-hot digit pulses; d[k] is digit pulse dk; all zero when halted.
- digit_idx  out  DW  current digit position; holds 0 when halted.
- minor_start  out  1  high coincident with d[0] of every generated minor cycle.
- minor_end  out  1  high coincident with d[DIGITS-1] of every generated minor cycle.
- cycle_odd  out  1  parity of completed minor cycles; toggles on the clock after minor_end.
- minor_count  out  MINOR_W  completed minor cycles, modulo 2^MINOR_W.
- running  out  1  1 while any minor cycle is being generated (RUN or STEP).
- step_done  out  1  one-cycle pulse on the clock after a STEP minor cycle completes.

Behaviour:
- Reset (takes priority over everything, including mid-cycle):
  - state=IDLE; d=0; digit_idx=0; minor_start=0; minor_end=0; cycle_odd=0; minor_count=0; running=0; step_done=0.
  - Any pending step request is cleared.
- d, minor_start and minor_end are registered and decoded from the registered digit_idx. They are only ever nonzero in RUN or STEP. d[k]=1 iff digit_idx==k.
- States:
  - IDLE:
    - run=1 -> RUN; the first d[0] appears on the clock after run is sampled high (latency 1).
    - Otherwise, stop_one=1 -> STEP, same latency.
    - run and stop_one both high -> RUN; the step request is discarded.
  - RUN:
    - digit_idx increments each clock and wraps DIGITS-1 -> 0.
    - At digit_idx==DIGITS-1: if run=1, continue at digit 0 with no gap clock; if run=0, go to IDLE.
    - Dropping run mid-cycle never truncates a minor cycle: all DIGITS pulses always appear.
    - stop_one while in RUN is ignored.
  - STEP:
    - Generates exactly one minor cycle.
    - At DIGITS-1 -> IDLE, and step_done=1 on the following clock.
    - run rising during STEP: the step cycle completes, then the block enters RUN with no gap; step_done is still asserted.
    - stop_one during STEP is ignored; it is not queued.
- At the end of every generated minor cycle (digit_idx==DIGITS-1), on the following clock: minor_count increments, wrapping at 2^MINOR_W, and cycle_odd toggles.
- running=1 in RUN and STEP, 0 in IDLE. It rises with the first d[0] and falls on the clock after the last d[DIGITS-1].
- Invariants, for the verifier to assert:
  - d is always zero or one-hot.
  - minor_start implies d[0].
  - minor_end implies d[DIGITS-1].
  - Between two minor_start pulses with running held high, exactly DIGITS clocks elapse.

Decomposition:
- Shared package `edsac_timing_pkg` holds:
  - DIGITS_DEFAULT=36;
  - state enum {IDLE, RUN, STEP};
  - localparams naming the control-consumed positions (D_SIGN=0, D_ADDR_LO=1, D_ORDER_HI=31, and so on).
- One sub-module, `digit_counter`: a mod-DIGITS counter with enable, wrap flag and synchronous clear.
- The top module holds the FSM, the one-hot decode register, the parity and minor-count register, and step_done.

Test Plan:
- Reset, then run=1 for 80 clocks with DIGITS=36:
  - d[0] appears at clock 1 after run, then at clocks 37 and 73.
  - minor_count=2 after clock 72; cycle_odd=0 at clock 73.
- Run active; drop run at digit_idx=10:
  - d continues through d[35]; next clock d=0, running=0, digit_idx=0.
- Idle; stop_one pulsed for 1 clock:
  - exactly 36 pulses d[0]..d[35]; step_done=1 on the clock after d[35]; minor_count=1; cycle_odd=1.
- stop_one pulsed again at digit 5 of a step, and again on the same clock as run in IDLE:
  - no extra minor cycle from either pulse; the simultaneous case enters RUN; step_done never asserts in the second case.
- reset asserted at digit_idx=20 in RUN with run held high:
  - next clock all outputs zero.
  - reset released with run=1: d[0] one clock later; minor_count restarts from 0.
- MINOR_W=3, continuous run for 9 minor cycles:
  - minor_count sequence 1..7, 0, 1.
  - d checked one-hot or zero on every clock.
